// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode and func3 encodings for the integer core
package core_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational branch/jump outcome and mispredict detection
module branch_resolve
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] ps1_data,
    input  logic [XLEN-1:0] ps2_data,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            taken,
    output logic            wr_en,
    output logic [XLEN-1:0] link,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mispredict
);

    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            known;

    assign br_target = pc + imm;
    assign jalr_sum  = ps1_data + imm;
    assign link      = pc + XLEN'(4);

    always_comb begin
        taken  = 1'b0;
        wr_en  = 1'b0;
        known  = 1'b0;
        target = br_target;
        case (opcode)
            OP_BRANCH: begin
                known = 1'b1;
                case (func3)
                    F3_BEQ:  taken = (ps1_data == ps2_data);
                    F3_BNE:  taken = (ps1_data != ps2_data);
                    F3_BLT:  taken = ($signed(ps1_data) <  $signed(ps2_data));
                    F3_BGE:  taken = ($signed(ps1_data) >= $signed(ps2_data));
                    F3_BLTU: taken = (ps1_data <  ps2_data);
                    F3_BGEU: taken = (ps1_data >= ps2_data);
                    default: known = 1'b0;
                endcase
            end
            OP_JAL: begin
                known = 1'b1;
                taken = 1'b1;
                wr_en = 1'b1;
            end
            OP_JALR: begin
                if (func3 == F3_JALR) begin
                    known  = 1'b1;
                    taken  = 1'b1;
                    wr_en  = 1'b1;
                    target = {jalr_sum[XLEN-1:1], 1'b0};
                end
            end
            default: known = 1'b0;
        endcase
    end

    assign redirect_pc = taken ? target : link;
    // Undecodable uops never raise a mispredict, whatever the front end guessed.
    assign mispredict  = known && ((taken != pred_taken) || (taken && (target != pred_target)));

endmodule

// File: rtl/fu_branch_pipe.sv
// rtl/fu_branch_pipe.sv - registered branch unit with output handshake, flush kill and mispredict counter
module fu_branch_pipe
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_DEPTH = 16,
    parameter int ROB_W     = $clog2(ROB_DEPTH),
    parameter int PREG_W    = 7,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [PREG_W-1:0] pd,
    input  logic [ROB_W-1:0]  rob_tag,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   pred_target,
    input  logic [XLEN-1:0]   ps1_data,
    input  logic [XLEN-1:0]   ps2_data,
    input  logic [ROB_W-1:0]  rob_head,
    input  logic              flush,
    input  logic [ROB_W-1:0]  flush_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROB_W-1:0]  out_rob_tag,
    output logic [PREG_W-1:0] out_pd,
    output logic              out_wr_en,
    output logic [XLEN-1:0]   out_data,
    output logic              out_taken,
    output logic [XLEN-1:0]   out_redirect_pc,
    output logic              out_mispredict,
    output logic [CNT_W-1:0]  mispredict_count
);

    typedef struct packed {
        logic [ROB_W-1:0]  rob_tag;
        logic [PREG_W-1:0] pd;
        logic              wr_en;
        logic [XLEN-1:0]   data;
        logic              taken;
        logic [XLEN-1:0]   redirect_pc;
        logic              mispredict;
    } b_result_t;

    b_result_t        res_q;
    b_result_t        res_d;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;

    logic             r_taken;
    logic             r_wr_en;
    logic [XLEN-1:0]  r_link;
    logic [XLEN-1:0]  r_redirect;
    logic             r_mispredict;

    branch_resolve #(.XLEN(XLEN)) u_resolve (
        .opcode      (opcode),
        .func3       (func3),
        .pc          (pc),
        .imm         (imm),
        .ps1_data    (ps1_data),
        .ps2_data    (ps2_data),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .taken       (r_taken),
        .wr_en       (r_wr_en),
        .link        (r_link),
        .redirect_pc (r_redirect),
        .mispredict  (r_mispredict)
    );

    // Ages are distances from the ROB head; ROB_DEPTH is a power of two so the subtraction wraps for free.
    logic [ROB_W-1:0] flush_age;
    logic [ROB_W-1:0] held_age;
    logic [ROB_W-1:0] in_age;
    logic             kill_held;
    logic             kill_in;
    logic             accept;
    logic             deliver;

    assign flush_age = flush_tag - rob_head;
    assign held_age  = res_q.rob_tag - rob_head;
    assign in_age    = rob_tag - rob_head;

    assign kill_held = flush && valid_q && (held_age > flush_age);
    assign kill_in   = flush && (in_age > flush_age);

    assign issue_ready = !valid_q || out_ready;
    assign accept      = issue_valid && issue_ready;
    assign deliver     = valid_q && out_ready && !kill_held;

    always_comb begin
        res_d             = '0;
        res_d.rob_tag     = rob_tag;
        res_d.wr_en       = r_wr_en;
        res_d.pd          = r_wr_en ? pd : '0;
        res_d.data        = r_wr_en ? r_link : '0;
        res_d.taken       = r_taken;
        res_d.redirect_pc = r_redirect;
        res_d.mispredict  = r_mispredict;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            count_q <= '0;
        end else begin
            if (accept && !kill_in) begin
                valid_q <= 1'b1;
                res_q   <= res_d;
            end else if (deliver || kill_held) begin
                valid_q <= 1'b0;
            end
            if (deliver && res_q.mispredict && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign out_valid        = valid_q;
    assign out_rob_tag      = res_q.rob_tag;
    assign out_pd           = res_q.pd;
    assign out_wr_en        = res_q.wr_en;
    assign out_data         = res_q.data;
    assign out_taken        = res_q.taken;
    assign out_redirect_pc  = res_q.redirect_pc;
    assign out_mispredict   = res_q.mispredict;
    assign mispredict_count = count_q;

endmodule
